// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder built around a single full_adder cell.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_ps;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_done;

  logic             w_fa_s;
  logic             w_fa_c;
  logic             w_last;
  logic [WIDTH-1:0] w_ps_nxt;

  full_adder u_fa (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .cin  (r_carry),
    .sum  (w_fa_s),
    .cout (w_fa_c)
  );

  assign w_last = (r_cnt == LAST);

  // The new sum bit enters at the MSB, so after WIDTH shifts bit 0 is the LSB.
  generate
    if (WIDTH == 1) begin : g_ps_w1
      assign w_ps_nxt = w_fa_s;
    end else begin : g_ps_wn
      assign w_ps_nxt = {w_fa_s, r_ps[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_ps    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_ps    <= w_ps_nxt;
          r_carry <= w_fa_c;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum  <= w_ps_nxt;
            r_cout <= w_fa_c;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // On the last RUN edge r_carry is the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_ovf <= r_carry ^ w_fa_c;
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1 against an arithmetic model.

module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf1;
`endif

  int unsigned n_checks;
  int unsigned n_pass;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #23;
    n_checks++; if (busy8 !== 1'b0) $display("FAIL reset_busy8 got %b want 0", busy8); else n_pass++;
    n_checks++; if (done8 !== 1'b0) $display("FAIL reset_done8 got %b want 0", done8); else n_pass++;
    n_checks++; if (sum8 !== 8'h00) $display("FAIL reset_sum8 got %h want 00", sum8); else n_pass++;
    n_checks++; if (cout8 !== 1'b0) $display("FAIL reset_cout8 got %b want 0", cout8); else n_pass++;
    n_checks++; if ({busy1, done1, sum1, cout1} !== 4'b0) $display("FAIL reset_dut1 got %b want 0000", {busy1, done1, sum1, cout1}); else n_pass++;
`ifdef SERIAL_ADDER_OVF_EN
    n_checks++; if ({ovf8, ovf1} !== 2'b00) $display("FAIL reset_ovf got %b want 00", {ovf8, ovf1}); else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    start_op8(8'h5A, 8'h33, 1'b0);
    n_checks++; if (busy8 !== 1'b1) $display("FAIL basic_busy_e0 got %b want 1", busy8); else n_pass++;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_checks++; if (busy8 !== (k <= 8)) $display("FAIL basic_busy_e%0d got %b want %b", k, busy8, (k <= 8)); else n_pass++;
      n_checks++; if (done8 !== (k == 8)) $display("FAIL basic_done_e%0d got %b want %b", k, done8, (k == 8)); else n_pass++;
      n_checks++; if (sum8 !== ((k >= 8) ? 8'h8D : 8'h00)) $display("FAIL basic_sum_e%0d got %h want %h", k, sum8, (k >= 8) ? 8'h8D : 8'h00); else n_pass++;
      n_checks++; if (cout8 !== 1'b0) $display("FAIL basic_cout_e%0d got %b want 0", k, cout8); else n_pass++;
`ifdef SERIAL_ADDER_OVF_EN
      n_checks++; if (ovf8 !== (k >= 8)) $display("FAIL basic_ovf_e%0d got %b want %b", k, ovf8, (k >= 8)); else n_pass++;
`endif
    end
  endtask

  task automatic test_carry();
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic       tc [3];
    logic [8:0] exp;
    ta[0] = 8'hFF; tb[0] = 8'h01; tc[0] = 1'b0;
    ta[1] = 8'hFF; tb[1] = 8'h00; tc[1] = 1'b1;
    ta[2] = 8'h80; tb[2] = 8'h80; tc[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = {1'b0, ta[i]} + {1'b0, tb[i]} + {8'd0, tc[i]};
      start_op8(ta[i], tb[i], tc[i]);
      for (int k = 1; k <= 8; k++) tick();
      n_checks++; if (done8 !== 1'b1) $display("FAIL carry%0d_done got %b want 1", i, done8); else n_pass++;
      n_checks++; if ({cout8, sum8} !== exp) $display("FAIL carry%0d_result got %h want %h", i, {cout8, sum8}, exp); else n_pass++;
`ifdef SERIAL_ADDER_OVF_EN
      n_checks++; if (ovf8 !== ((ta[i][7] == tb[i][7]) && (exp[7] != ta[i][7]))) $display("FAIL carry%0d_ovf got %b want %b", i, ovf8, (ta[i][7] == tb[i][7]) && (exp[7] != ta[i][7])); else n_pass++;
`endif
      tick();
      n_checks++; if ({busy8, done8} !== 2'b00) $display("FAIL carry%0d_idle got %b want 00", i, {busy8, done8}); else n_pass++;
    end
  endtask

  task automatic test_ignore_busy();
    start_op8(8'h10, 8'h20, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end
      tick();
      if (k == 3) start8 = 1'b0;
      if (k < 8) begin
        n_checks++; if ({cout8, sum8} !== 9'h100) $display("FAIL ignore_hold_e%0d got %h want 100", k, {cout8, sum8}); else n_pass++;
      end
      n_checks++; if (done8 !== (k == 8)) $display("FAIL ignore_done_e%0d got %b want %b", k, done8, (k == 8)); else n_pass++;
    end
    n_checks++; if ({cout8, sum8} !== 9'h030) $display("FAIL ignore_result got %h want 030", {cout8, sum8}); else n_pass++;
    n_checks++; if (busy8 !== 1'b0) $display("FAIL ignore_no_restart got %b want 0", busy8); else n_pass++;
  endtask

  task automatic test_reset_mid();
    start_op8(8'h5A, 8'h33, 1'b0);
    for (int k = 1; k <= 4; k++) tick();
    rst_n = 1'b0;
    #2;
    n_checks++; if ({busy8, done8, cout8, sum8} !== 11'd0) $display("FAIL midreset_clear got %h want 000", {busy8, done8, cout8, sum8}); else n_pass++;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++; if ({busy8, done8} !== 2'b00) $display("FAIL midreset_quiet_%0d got %b want 00", k, {busy8, done8}); else n_pass++;
    end
    start_op8(8'h01, 8'h02, 1'b0);
    for (int k = 1; k <= 8; k++) tick();
    n_checks++; if ({done8, cout8, sum8} !== {1'b1, 9'h003}) $display("FAIL midreset_fresh got %h want 203", {done8, cout8, sum8}); else n_pass++;
    tick();
  endtask

  task automatic test_width1();
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n_checks++; if ({busy1, done1} !== 2'b10) $display("FAIL w1_e0 got %b want 10", {busy1, done1}); else n_pass++;
    tick();
    n_checks++; if ({done1, cout1, sum1} !== 3'b111) $display("FAIL w1_e1 got %b want 111", {done1, cout1, sum1}); else n_pass++;
`ifdef SERIAL_ADDER_OVF_EN
    n_checks++; if (ovf1 !== 1'b0) $display("FAIL w1_ovf got %b want 0", ovf1); else n_pass++;
`endif
    tick();
    n_checks++; if ({busy1, done1} !== 2'b00) $display("FAIL w1_e2 got %b want 00", {busy1, done1}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp1;
    logic [8:0] exp8, prev8;
    logic [7:0] ra, rb;
    logic       rc;
    // WIDTH=1: start held high, operands scrambled while busy
    start1 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      exp1 = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
      tick();
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      tick();
      n_checks++; if ({done1, cout1, sum1} !== {1'b1, exp1}) $display("FAIL b2b1_%0d got %b want %b", i, {done1, cout1, sum1}, {1'b1, exp1}); else n_pass++;
      tick();
      n_checks++; if ({busy1, done1} !== 2'b00) $display("FAIL b2b1_idle_%0d got %b want 00", i, {busy1, done1}); else n_pass++;
    end
    start1 = 1'b0;
    // WIDTH=8: restart at the earliest legal edge each time
    prev8 = {cout8, sum8};
    start8 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      a8 = ra; b8 = rb; cin8 = rc;
      exp8 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      tick();
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      for (int k = 1; k <= 7; k++) tick();
      n_checks++; if ({cout8, sum8} !== prev8) $display("FAIL b2b8_hold_%0d got %h want %h", i, {cout8, sum8}, prev8); else n_pass++;
      tick();
      n_checks++; if ({done8, cout8, sum8} !== {1'b1, exp8}) $display("FAIL b2b8_%0d got %h want %h", i, {done8, cout8, sum8}, {1'b1, exp8}); else n_pass++;
`ifdef SERIAL_ADDER_OVF_EN
      n_checks++; if (ovf8 !== ((ra[7] == rb[7]) && (exp8[7] != ra[7]))) $display("FAIL b2b8_ovf_%0d got %b want %b", i, ovf8, (ra[7] == rb[7]) && (exp8[7] != ra[7])); else n_pass++;
`endif
      tick();
      n_checks++; if (busy8 !== 1'b0) $display("FAIL b2b8_idle_%0d got %b want 0", i, busy8); else n_pass++;
      prev8 = exp8;
    end
    start8 = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_carry();
    test_ignore_busy();
    test_reset_mid();
    test_width1();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
